// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, initial hash value, FSM state type and
// the 32-bit round/schedule helper functions.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 512;
  localparam int unsigned DIG_W  = 256;

  // H0 occupies the most significant word
  localparam logic [DIG_W-1:0] SHA256_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  typedef enum logic [2:0] {StIdle, StLoad, StRound, StFinal, StDone} state_e;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                           input logic [WORD_W-1:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x,
                                            input logic [WORD_W-1:0] y,
                                            input logic [WORD_W-1:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress_core_w_schedule.sv
// SHA-256 message schedule as a 16-word sliding window.
//   clk, rst_n : clock, async active-low reset
//   load_i     : load the window from blk_i (W0 = blk_i[511:480])
//   shift_i    : advance one word; the new tail word is W[t+16]
//   blk_i      : 512-bit message block
//   wt_o       : current schedule word W[t] (window head)
module sha256_w_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [BLK_W-1:0]  blk_i,
  output logic [WORD_W-1:0] wt_o
);

  logic [15:0][WORD_W-1:0] w_q, w_d;
  logic [WORD_W-1:0]       w_new;

  // With the head at W[t], the tail word W[t+16] depends on W[t+14], W[t+9], W[t+1], W[t]
  assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

  always_comb begin
    w_d = w_q;
    if (load_i) begin
      for (int i = 0; i < 16; i++) w_d[i] = blk_i[BLK_W-1-WORD_W*i -: WORD_W];
    end else if (shift_i) begin
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15] = w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= '0;
    else        w_q <= w_d;
  end

  assign wt_o = w_q[0];

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 compression core, one round per clock, fed by an external K-constant stream.
//   clk, rst_n            : clock, async active-low reset
//   blk_valid_i/ready_o   : block handshake; blk_data_i (W0 in MSBs), blk_first_i (1 = start from IV)
//   k_restart_o           : registered one-cycle pulse in LOAD, drives the K machine's sync reset
//   k_in_i                : K[t] stream, valid in ROUND
//   dig_valid_o/ready_i   : digest handshake; dig_data_o = H0..H7 (H0 in MSBs)
//   busy_o                : high whenever not idle
module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter logic [DIG_W-1:0] Iv     = SHA256_IV,
  parameter int unsigned      Rounds = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blk_valid_i,
  output logic              blk_ready_o,
  input  logic [BLK_W-1:0]  blk_data_i,
  input  logic              blk_first_i,
  output logic              k_restart_o,
  input  logic [WORD_W-1:0] k_in_i,
  output logic              dig_valid_o,
  input  logic              dig_ready_i,
  output logic [DIG_W-1:0]  dig_data_o,
  output logic              busy_o
);

  state_e                   state_q, state_d;
  logic                     k_restart_q, k_restart_d;
  logic                     first_q, first_d;
  logic [6:0]               t_q, t_d;
  logic [0:7][WORD_W-1:0]   h_q, h_d;  // chaining value, index 0 = H0
  logic [0:7][WORD_W-1:0]   v_q, v_d;  // working variables a..h
  logic [0:7][WORD_W-1:0]   base;
  logic [WORD_W-1:0]        wt, t1, t2;
  logic                     accept;

  assign accept = blk_valid_i & blk_ready_o;

  // The window is filled on the accept edge rather than in LOAD: it does not shift until
  // ROUND, so LOAD sees the same contents without a separate 512-bit capture register.
  sha256_w_schedule u_w_schedule (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .shift_i (state_q == StRound),
    .blk_i   (blk_data_i),
    .wt_o    (wt)
  );

  always_comb begin
    state_d     = state_q;
    k_restart_d = 1'b0;
    first_d     = first_q;
    t_d         = t_q;
    h_d         = h_q;
    v_d         = v_q;
    base        = first_q ? Iv : h_q;
    t1          = v_q[7] + bsig1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + k_in_i + wt;
    t2          = bsig0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StLoad;
          first_d     = blk_first_i;
          k_restart_d = 1'b1;
        end
      end
      StLoad: begin
        v_d     = base;
        t_d     = '0;
        state_d = StRound;
      end
      StRound: begin
        v_d = {t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
        t_d = t_q + 7'd1;
        if (t_q == 7'(Rounds - 1)) state_d = StFinal;
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) h_d[i] = base[i] + v_q[i];
        state_d = StDone;
      end
      StDone: begin
        if (dig_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_restart_q <= 1'b0;
      first_q     <= 1'b0;
      t_q         <= '0;
      h_q         <= Iv;
      v_q         <= '0;
    end else begin
      state_q     <= state_d;
      k_restart_q <= k_restart_d;
      first_q     <= first_d;
      t_q         <= t_d;
      h_q         <= h_d;
      v_q         <= v_d;
    end
  end

  assign blk_ready_o = (state_q == StIdle);
  assign k_restart_o = k_restart_q;
  assign dig_valid_o = (state_q == StDone);
  assign dig_data_o  = dig_valid_o ? h_q : '0;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_sha256_compress_core.sv
module tb_sha256_compress_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         k_restart;
  logic [31:0]  k_in;
  logic         dig_valid;
  logic         dig_ready = 1'b1;
  logic [255:0] dig_data;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [255:0] d;
    bit           chk;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    string        name;
    logic [511:0] blk;
    bit           first;
    logic [255:0] exp;
    bit           chk;
  } vec_t;
  vec_t vt[4];

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // K constant machine: sync active-high reset, K[0] the cycle after reset
  logic [5:0] kidx = '0;
  always_ff @(posedge clk) begin
    if (k_restart) kidx <= '0;
    else           kidx <= kidx + 6'd1;
  end
  assign k_in = KTAB[kidx];

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  sha256_compress_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_valid_i (blk_valid),
    .blk_ready_o (blk_ready),
    .blk_data_i  (blk_data),
    .blk_first_i (blk_first),
    .k_restart_o (k_restart),
    .k_in_i      (k_in),
    .dig_valid_o (dig_valid),
    .dig_ready_i (dig_ready),
    .dig_data_o  (dig_data),
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {251'(0), blk_ready, k_restart, dig_valid, busy, |dig_data},
        {251'(0), 5'b10000});
  endtask

  // Offer a block, wait (bounded) for acceptance, push its expected digest
  task automatic send_block(input logic [511:0] blk, input bit first, input logic [255:0] exp,
                            input bit check);
    exp_t e;
    bit   got = 0;
    blk_valid = 1'b1;
    blk_data  = blk;
    blk_first = first;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (blk_ready) got = 1;
    end
    if (!got) chk("accept_timeout", 256'(0), 256'(1));
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    e.d       = exp;
    e.chk     = check;
    exp_q.push_back(e);
    blk_valid = 1'b0;
  endtask

  // Watch one block from LOAD to DONE; rel is the cycle number with LOAD = 1
  task automatic wait_digest(input string name, input bit consume);
    int pulses = 0;
    int pulse_rel = -1;
    int rel;
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      rel = cyc - acc_cyc + 1;
      if (k_restart) begin
        pulses++;
        pulse_rel = rel;
      end
      if (rel == 2)  chk({name, "_k_first"}, 256'(k_in), 256'h428a2f98);
      if (rel == 65) chk({name, "_k_last"}, 256'(k_in), 256'hc67178f2);
      if (dig_valid) begin
        got = 1;
        chk({name, "_latency"}, 256'(rel), 256'(67));
        chk({name, "_k_pulse"}, {224'(0), 32'(pulses), 32'(pulse_rel)},
            {224'(0), 32'(1), 32'(1)});
        if (exp_q.size() == 0) chk({name, "_unexpected_digest"}, 256'(0), 256'(1));
        else if (exp_q[0].chk) chk({name, "_digest"}, dig_data, exp_q[0].d);
        if (consume && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          @(posedge clk);
          #1;
        end
      end
    end
    if (!got) chk({name, "_digest_timeout"}, 256'(0), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"abc", {32'h61626380, 448'h0, 32'h00000018}, 1'b1, DIG_ABC, 1'b1};
    vt[1] = '{"empty", {32'h80000000, 480'h0}, 1'b1,
              256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 1'b1};
    vt[2] = '{"two_blk1", {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                           32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                           32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
              1'b1, 256'h0, 1'b0};
    vt[3] = '{"two_blk2", {480'h0, 32'h000001c0}, 1'b0,
              256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors; dig_ready stays high
    for (int v = 0; v < 4; v++) begin
      send_block(vt[v].blk, vt[v].first, vt[v].exp, vt[v].chk);
      wait_digest(vt[v].name, 1'b1);
    end

    // Backpressure: sink stalls 20 cycles while a new block is offered
    dig_ready = 1'b0;
    send_block(vt[0].blk, 1'b1, DIG_ABC, 1'b1);
    wait_digest("bp", 1'b0);
    blk_valid = 1'b1;
    blk_data  = vt[1].blk;
    blk_first = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold", {dig_valid, blk_ready, 254'(0)} ^ dig_data, {2'b10, 254'(0)} ^ DIG_ABC);
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    dig_ready = 1'b1;
    @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk_idle_outputs("bp_release");

    // Reset mid-ROUND at t=30, then rerun "abc" chaining from H (= IV after reset)
    send_block(vt[0].blk, 1'b1, DIG_ABC, 1'b1);
    repeat (32) @(negedge clk);
    chk("mid_busy", 256'(busy), 256'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset_outputs");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_block(vt[0].blk, 1'b0, DIG_ABC, 1'b1);
    wait_digest("rerun_abc_first0", 1'b1);
    send_block(vt[0].blk, 1'b1, DIG_ABC, 1'b1);
    wait_digest("rerun_abc_first1", 1'b1);
    chk("queue_empty", 256'(exp_q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
